// File: rtl/pipe_regfile_hilo_if.sv
// Write-back / read-port bundle between the pipeline and pipe_regfile_hilo.
// The master side is the pipeline (or the bench); the slave side is the register file.
interface pipe_regfile_hilo_if #(
    parameter int DATA_W = 32
);
    // WB write channel
    logic [4:0]        Wrn;
    logic [DATA_W-1:0] Wdata_rf;
    logic              Ww_rf;
    logic [DATA_W-1:0] Wdata_hi;
    logic              Ww_hi;
    logic [DATA_W-1:0] Wdata_lo;
    logic              Ww_lo;
    // ID read ports
    logic [4:0]        rna;
    logic [4:0]        rnb;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    // debug / bookkeeping
    logic [4:0]        dbg_rn;
    logic [DATA_W-1:0] dbg_q;
    logic [31:0]       wcount;

    modport master (
        output Wrn, Wdata_rf, Ww_rf, Wdata_hi, Ww_hi, Wdata_lo, Ww_lo,
        output rna, rnb, dbg_rn,
        input  qa, qb, hi, lo, dbg_q, wcount
    );

    modport slave (
        input  Wrn, Wdata_rf, Ww_rf, Wdata_hi, Ww_hi, Wdata_lo, Ww_lo,
        input  rna, rnb, dbg_rn,
        output qa, qb, hi, lo, dbg_q, wcount
    );
endinterface

// File: rtl/pipe_regfile_hilo.sv
// Architectural GPR file (r0 hardwired to zero) plus HI/LO pair.
// WB writes commit on the rising edge; the read ports can see a write in the
// same cycle it is presented, so ID needs no separate WB forwarding path.
module pipe_regfile_hilo #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1
) (
    input logic                clk,
    input logic                rst,
    pipe_regfile_hilo_if.slave bus
);
    logic [DATA_W-1:0] regs    [1:31];
    logic [DATA_W-1:0] rf_view [0:31];
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [DATA_W-1:0] dbg_r;
    logic [31:0]       wcount_r;
    logic              commit_rf;
    logic              byp_a;
    logic              byp_b;

    // A write to r0 or a write presented while reset is high never commits.
    assign commit_rf = !rst && bus.Ww_rf && (bus.Wrn != 5'd0);

    // Stored-value view of all 32 addresses, with r0 reading as zero.
    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < 32; i++) rf_view[i] = regs[i];
    end

    // GPR storage: clear on reset, otherwise decode Wrn to one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++)
                if (commit_rf && (bus.Wrn == 5'(i))) regs[i] <= bus.Wdata_rf;
        end
    end

    // HI and LO commit independently of each other and of the GPR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            if (bus.Ww_hi) hi_r <= bus.Wdata_hi;
            if (bus.Ww_lo) lo_r <= bus.Wdata_lo;
        end
    end

    // Debug read samples stored contents before this edge's commit.
    always_ff @(posedge clk) begin
        if (rst) dbg_r <= '0;
        else     dbg_r <= rf_view[bus.dbg_rn];
    end

    // Count committed GPR writes; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst)            wcount_r <= '0;
        else if (commit_rf) wcount_r <= wcount_r + 32'd1;
    end

    // Read ports: r0 first, then same-cycle bypass, then stored value.
    always_comb begin
        byp_a = BYPASS && !rst && bus.Ww_rf && (bus.Wrn == bus.rna);
        byp_b = BYPASS && !rst && bus.Ww_rf && (bus.Wrn == bus.rnb);
        if (bus.rna == 5'd0) bus.qa = '0;
        else if (byp_a)      bus.qa = bus.Wdata_rf;
        else                 bus.qa = rf_view[bus.rna];
        if (bus.rnb == 5'd0) bus.qb = '0;
        else if (byp_b)      bus.qb = bus.Wdata_rf;
        else                 bus.qb = rf_view[bus.rnb];
    end

    assign bus.hi     = (BYPASS && bus.Ww_hi && !rst) ? bus.Wdata_hi : hi_r;
    assign bus.lo     = (BYPASS && bus.Ww_lo && !rst) ? bus.Wdata_lo : lo_r;
    assign bus.dbg_q  = dbg_r;
    assign bus.wcount = wcount_r;
endmodule

// File: doc/pipe_regfile_hilo.md
# pipe_regfile_hilo

Architectural register file and HI/LO register pair for the dynamic pipelined CPU; it is the receiving end of the write-back stage's `Wrn`/`Wdata_*`/`Ww_*` interface. It commits WB writes on the clock edge and serves the ID stage's two GPR read ports and the HI/LO read path. Same-cycle write-to-read bypass means ID never needs an extra forwarding path from WB. It also provides a registered debug read port and a committed-write counter for the bench.

## Interface
- `DATA_W`, default 32: width of every GPR, HI and LO.
- `BYPASS`, default 1: 1 enables same-cycle WB-to-read bypass; 0 returns stored values only.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Wrn` in 5: WB destination register number.
- `Wdata_rf` in DATA_W: WB data for the GPR.
- `Ww_rf` in 1: GPR write enable.
- `Wdata_hi` in DATA_W: HI write data.
- `Ww_hi` in 1: HI write enable.
- `Wdata_lo` in DATA_W: LO write data.
- `Ww_lo` in 1: LO write enable.
- `rna` in 5: ID read port A address.
- `rnb` in 5: ID read port B address.
- `qa` out DATA_W: port A data, combinational.
- `qb` out DATA_W: port B data, combinational.
- `hi` out DATA_W: current HI, combinational, bypassed.
- `lo` out DATA_W: current LO, combinational, bypassed.
- `dbg_rn` in 5: debug read address.
- `dbg_q` out DATA_W: debug read data, registered, one-cycle latency, no bypass.
- `wcount` out 32: count of committed GPR writes.

## Operation
- Storage:
  - Registers 1..31 are DATA_W flops each.
  - Register 0 is not stored. It always reads 0, and writes to it are discarded.
  - `hi_r` and `lo_r` are DATA_W flops.
- GPR commit:
  - Condition: rising edge with `rst`=0, `Ww_rf`=1 and `Wrn`≠0.
  - Action: `reg[Wrn]` ← `Wdata_rf`.
- HI/LO commit: `Ww_hi` and `Ww_lo` are independent. Both may fire in the same cycle, and both may fire together with a GPR write.
- Port read (A shown; B identical):
  - `rna`=0 → 0.
  - Else, if BYPASS=1 and `Ww_rf`=1 and `Wrn`=`rna` and `rst`=0 → `Wdata_rf`.
  - Else → `reg[rna]`.
- HI/LO read:
  - `hi` = (BYPASS && `Ww_hi` && !`rst`) ? `Wdata_hi` : `hi_r`.
  - `lo` follows the same rule with `Ww_lo`, `Wdata_lo` and `lo_r`.
- Debug port:
  - Each edge, `dbg_q` ← (`dbg_rn`=0 ? 0 : `reg[dbg_rn]`), sampled before that edge's commit.
  - The debug port sees a write one cycle after it commits.
- Counter:
  - `wcount` increments by 1 on each edge where a GPR commit occurs.
  - It wraps from 0xFFFFFFFF to 0.
  - Ignored writes (to r0, or during reset) do not count.
- Both read ports may address the same register, and either may match `Wrn`; each port resolves independently.

## Timing
- Reset (`rst`=1 at an edge):
  - r1..r31, `hi_r`, `lo_r`, `dbg_q` and `wcount` all become 0.
  - All WB writes presented in that cycle are dropped.
- Outputs while `rst` is held:
  - Bypass is suppressed.
  - `qa`, `qb`, `hi` and `lo` show stored values, which are 0 after the first reset edge.
- Reset asserted mid-stream: a write presented in the same cycle as `rst` is lost. Writes resume on the first edge after `rst` drops.
- Write latency: one edge to storage.
- Read latency:
  - With BYPASS=1, `qa`, `qb`, `hi` and `lo` show the new value in the same cycle the write is presented.
  - With BYPASS=0, they show it the cycle after.
- `dbg_q`: one-cycle registered latency. It sees committed data only, never bypassed data.
- No handshake: WB writes are unconditional when enabled, and the block never stalls.

## Test plan
- Reset, then read all 32 addresses on `rna` and `rnb`, plus `hi`, `lo` → every value is 0; `wcount`=0.
- `Ww_rf`=1, `Wrn`=5, `Wdata_rf`=0xDEADBEEF, with `rna`=5 in the same cycle:
  - Same cycle → `qa`=0xDEADBEEF (bypass).
  - After the edge, with `Ww_rf`=0 → `qa`=0xDEADBEEF.
  - `dbg_rn`=5 → `dbg_q`=0xDEADBEEF one edge later.
  - `wcount`=1.
- `Ww_rf`=1, `Wrn`=0, `Wdata_rf`=0x12345678, with `rna`=`rnb`=0 → `qa`=`qb`=0 both before and after the edge; `wcount` unchanged.
- Same cycle: `Ww_hi`=1 with 0xAAAA0000, `Ww_lo`=1 with 0x0000BBBB, `Ww_rf`=1 to r31 with 0x1:
  - Same cycle → `hi`, `lo` and `qb`(`rnb`=31) show the new values.
  - All three persist after the edge.
- Write r7=0x77 and commit. Next cycle, present a write r7=0x99 with `rst`=1:
  - After that edge → r7=0, `hi`=`lo`=0, `wcount`=0.
  - A write on the first edge after `rst` drops commits normally.
- Preload `wcount`=0xFFFFFFFE by stepping the bench past it via forced state, then commit two writes to r3 → `wcount` goes to 0xFFFFFFFF, then to 0.
